// File: rtl/apb_master_bridge.sv
// apb_master_bridge: accepts one command at a time and runs it as an APB transfer,
// returning read data / error on a valid-ready response channel. All outputs are flops.
module apb_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // SETUP  | APB setup phase, PSEL=1 PENABLE=0, one cycle
  // ACCESS | APB access phase, waiting for PREADY or timeout
  // RESP   | rsp_valid high until the consumer takes it
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // TIMEOUT is limited to 2..255 so the wait count fits in 8 bits.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic                  cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ACCESS: begin
        // PREADY wins over a timeout landing on the same edge
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed commands against a small APB completer model,
// responses checked by a scoreboard monitor fed from the stimulus.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // completer model: memory with programmable wait states, error and never-ready modes
  int          ready_delay = 0;
  logic        never_ready = 1'b0;
  logic        slverr_mode = 1'b0;
  logic        mem_clr     = 1'b1;
  int          acc_cnt     = 0;
  logic [31:0] mem     [0:1023];
  logic        written [0:1023];
  logic        in_access;

  assign in_access = PSEL && PENABLE;
  assign PREADY  = in_access ? (!never_ready && acc_cnt == ready_delay) : 1'b1;
  assign PSLVERR = in_access ? slverr_mode : 1'b1;
  assign PRDATA  = !in_access ? 32'hBAD0BAD0 :
                   written[PADDR] ? mem[PADDR] : (32'hC0DE0000 | {22'd0, PADDR});

  always @(posedge PCLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
    end else if (in_access && PREADY && PWRITE) begin
      mem[PADDR]     <= PWDATA;
      written[PADDR] <= 1'b1;
    end
    if (in_access && !PREADY) acc_cnt <= acc_cnt + 1;
    else                      acc_cnt <= 0;
  end

  // APB phase counters and address/data stability against the current command
  int          setup_cnt, pen_cnt, pwr_cnt;
  logic        cur_write;
  logic [9:0]  cur_addr;
  logic [31:0] cur_wdata;

  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) setup_cnt++;
    if (PSEL && PENABLE)  pen_cnt++;
    if (PSEL && PWRITE)   pwr_cnt++;
    if (PSEL) begin
      chk("apb_paddr", PADDR, cur_addr);
      chk("apb_pwrite", PWRITE, cur_write);
      if (cur_write) chk("apb_pwdata", PWDATA, cur_wdata);
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  always @(negedge PCLK) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [9:0] addr, input logic [31:0] wdata);
    bit ok;
    cur_write = wr;
    cur_addr  = addr;
    cur_wdata = wdata;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("cmd_accept_timeout", cmd_ready, 1'b1);
    setup_cnt = 0;
    pen_cnt   = 0;
    pwr_cnt   = 0;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                        input int delay, input logic nready, input logic serr,
                        input logic [31:0] e_rdata, input logic e_err, input int e_pen,
                        input int hold);
    bit   got;
    rsp_t e;
    ready_delay = delay;
    never_ready = nready;
    slverr_mode = serr;
    e.rdata = e_rdata;
    e.err   = e_err;
    exp_q.push_back(e);
    issue(wr, addr, wdata);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin got = 1; break; end
      tick();
    end
    if (!got) chk("rsp_wait_timeout", rsp_valid, 1'b1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_err", rsp_err, e_err);
      chk("hold_rsp_rdata", rsp_rdata, e_rdata);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 1'b0);
    chk("post_cmd_ready", cmd_ready, 1'b1);
    chk("setup_cycles", setup_cnt, 1);
    chk("penable_cycles", pen_cnt, e_pen);
    if (!wr) chk("read_pwrite_seen", pwr_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want <100000", $time);
    $fatal(1);
  end

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    cur_write = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    setup_cnt = 0;
    pen_cnt   = 0;
    pwr_cnt   = 0;
    repeat (3) tick();
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 10'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    PRESET  = 1'b0;
    mem_clr = 1'b0;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1'b1);

    // wr, addr, wdata, delay, never_ready, slverr, exp rdata, exp err, PENABLE cycles, hold
    do_cmd(1'b1, 10'h001, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'h00000000, 1'b0, 2, 0);
    do_cmd(1'b0, 10'h001, 32'h00000000, 1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 2, 0);
    do_cmd(1'b1, 10'h3FF, 32'h12345678, 0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1, 0);
    do_cmd(1'b0, 10'h3FF, 32'h00000000, 2, 1'b0, 1'b0, 32'h12345678, 1'b0, 3, 0);
    do_cmd(1'b0, 10'h3FF, 32'h00000000, 0, 1'b1, 1'b0, 32'h00000000, 1'b1, 4, 0);
    do_cmd(1'b1, 10'h002, 32'hAAAA5555, 0, 1'b1, 1'b0, 32'h00000000, 1'b1, 4, 0);
    do_cmd(1'b0, 10'h002, 32'h00000000, 0, 1'b0, 1'b0, 32'hC0DE0002, 1'b0, 1, 0);
    do_cmd(1'b0, 10'h001, 32'h00000000, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1, 5);
    do_cmd(1'b0, 10'h001, 32'h00000000, 3, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 4, 0);
    do_cmd(1'b1, 10'h004, 32'h0BADF00D, 3, 1'b0, 1'b1, 32'h00000000, 1'b1, 4, 2);

    // reset in the middle of ACCESS drops the transfer
    never_ready = 1'b1;
    issue(1'b1, 10'h005, 32'h00000055);
    chk("mid_setup_psel", PSEL, 1'b1);
    chk("mid_setup_penable", PENABLE, 1'b0);
    tick();
    chk("mid_access_penable", PENABLE, 1'b1);
    PRESET = 1'b1;
    tick();
    chk("mid_rst_psel", PSEL, 1'b0);
    chk("mid_rst_penable", PENABLE, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    PRESET = 1'b0;
    tick();
    chk("mid_rel_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_rsp", rsp_valid, 1'b0);
      tick();
    end
    do_cmd(1'b0, 10'h005, 32'h00000000, 0, 1'b0, 1'b0, 32'hC0DE0005, 1'b0, 1, 0);

    repeat (2) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS cycles before abort; legal values are 2..255.
REQ-004 Port PCLK, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port PRESET, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port cmd_valid, input, 1 bit: a command is offered.
REQ-007 Port cmd_ready, output, 1 bit: the bridge can accept a command.
REQ-008 Port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port cmd_addr, input, ADDR_WIDTH bits: target address.
REQ-010 Port cmd_wdata, input, DATA_WIDTH bits: write data.
REQ-011 Port rsp_valid, output, 1 bit: a response is available.
REQ-012 Port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-013 Port rsp_rdata, output, DATA_WIDTH bits: read data; 0 for writes and for timeouts.
REQ-014 Port rsp_err, output, 1 bit: the transfer ended with PSLVERR or a timeout.
REQ-015 Ports PSEL, PENABLE and PWRITE, outputs, 1 bit each; PADDR, output, ADDR_WIDTH bits; PWDATA, output, DATA_WIDTH bits: the APB requester signals.
REQ-016 Ports PRDATA (input, DATA_WIDTH bits), PREADY (input, 1 bit) and PSLVERR (input, 1 bit): the APB completer signals.

Function
REQ-017 SHALL implement an FSM with exactly four states, IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1, and its write flag, address and write data are captured.
REQ-019 On acceptance, the FSM SHALL go IDLE to SETUP, and in SETUP drive PSEL=1, PENABLE=0, with PADDR, PWRITE and PWDATA set from the captured command.
REQ-020 SETUP SHALL last exactly one cycle, then go to ACCESS, with PSEL=1 and PENABLE=1.
REQ-021 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the end of ACCESS; in IDLE they hold their last values.
REQ-022 In ACCESS, on an edge where PREADY=1, the FSM SHALL go to RESP, drive PSEL=0 and PENABLE=0, set rsp_err to PSLVERR, and set rsp_rdata to PRDATA for reads or to 0 for writes.
REQ-023 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with PREADY=0.
REQ-024 When PREADY=0 and the wait counter equals TIMEOUT-1, the FSM SHALL abort: go to RESP, set rsp_err=1 and rsp_rdata=0, and drive PSEL=0 and PENABLE=0.
REQ-025 As a result of REQ-023 and REQ-024, PENABLE SHALL be high for at most TIMEOUT cycles per transfer.
REQ-026 If PREADY=1 on the same edge the timeout would fire, the transfer SHALL complete normally; PREADY takes priority.
REQ-027 In RESP, rsp_valid=1 and rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, after which the FSM goes to IDLE with rsp_valid=0.
REQ-028 Minimum command-to-command spacing SHALL be 4 cycles: SETUP, ACCESS, RESP, then IDLE; there is no back-to-back pipelining.
REQ-029 PREADY, PRDATA and PSLVERR SHALL be ignored outside ACCESS.
REQ-030 cmd_valid SHALL be ignored outside IDLE; commands are never queued.

Reset
REQ-031 While PRESET=1 at an edge, the FSM SHALL go to IDLE and the bridge SHALL drive PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and wait counter=0.
REQ-032 cmd_ready SHALL go to 1 on the first edge after PRESET deasserts.
REQ-033 A reset during SETUP, ACCESS or RESP SHALL drop the transfer: PSEL and PENABLE go to 0 at that edge, and no response is ever produced.

Verification
REQ-034 Write: with the completer setting PREADY one cycle after PSEL&PENABLE, issue cmd write addr 0x001 data 0xDEADBEEF -> exactly one SETUP cycle, PENABLE high for 2 cycles, then rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-035 Read-back: issue cmd read addr 0x001 after REQ-034 -> rsp_rdata=0xDEADBEEF, rsp_err=0, and PWRITE=0 throughout.
REQ-036 Timeout: with TIMEOUT=4 and PREADY tied 0, issue read addr 0x3FF -> PENABLE high for exactly 4 cycles, then rsp_err=1, rsp_rdata=0.
REQ-037 Error and backpressure: PSLVERR=1 with PREADY=1, and rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_err=1 stay stable for 5 cycles, cmd_ready stays 0, and IDLE is entered 1 cycle after rsp_ready=1.
REQ-038 Reset mid-ACCESS: assert PRESET for 1 cycle during ACCESS -> PSEL=0 and PENABLE=0 at the next edge, rsp_valid never pulses, cmd_ready=1 one cycle after release.
REQ-039 Priority: PREADY=1 coincides with the wait counter at TIMEOUT-1 -> rsp_err equals PSLVERR, not a forced 1.
